// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg_if : valid/ready/payload bundle for one pipeline boundary
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg : skid-buffered pipeline register with flush and stall count
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, main_nxt;
  logic [DATA_W-1:0] skid_data, skid_nxt;
  logic              in_ready_q, in_ready_nxt;
  logic              out_valid;
  logic              accept;
  logic              drain;

  assign out_valid = (state != EMPTY);
  assign accept    = up.valid & in_ready_q;
  assign drain     = out_valid & dn.ready;

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid;
  assign dn.data   = main_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      main_data  <= FLUSH_VAL;
      skid_data  <= FLUSH_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      main_data  <= main_nxt;
      skid_data  <= skid_nxt;
      in_ready_q <= in_ready_nxt;
    end
  end

  // Emptied entries are reloaded with FLUSH_VAL so a bubble always reads as a NOP.
  always_comb begin
    state_nxt    = state;
    main_nxt     = main_data;
    skid_nxt     = skid_data;
    in_ready_nxt = in_ready_q;
    if (flush) begin
      state_nxt    = EMPTY;
      main_nxt     = FLUSH_VAL;
      skid_nxt     = FLUSH_VAL;
      in_ready_nxt = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_nxt  = up.data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_nxt = up.data;
          end else if (accept) begin
            skid_nxt     = up.data;
            state_nxt    = TWO;
            in_ready_nxt = 1'b0;
          end else if (drain) begin
            main_nxt  = FLUSH_VAL;
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_nxt     = skid_data;
            skid_nxt     = FLUSH_VAL;
            state_nxt    = ONE;
            in_ready_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt    = EMPTY;
          main_nxt     = FLUSH_VAL;
          skid_nxt     = FLUSH_VAL;
          in_ready_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !dn.ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg : directed scoreboard bench for pipe_stage_reg
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [DATA_W-1:0] exp_q[$];
  int                checks = 0;
  int                errors = 0;

  pipe_stage_reg_if #(.DATA_W(DATA_W)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DATA_W)) dn_if ();

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .FLUSH_VAL({DATA_W{1'b0}}),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .up       (up_if),
    .dn       (dn_if),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a beat after a rising edge; push it to the scoreboard once accepted.
  task automatic send(input logic [DATA_W-1:0] d);
    logic rdy;
    int   tries;
    tries       = 0;
    up_if.valid = 1'b1;
    up_if.data  = d;
    do begin
      @(negedge clk);
      rdy = up_if.ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!rdy && tries < 50);
    if (rdy) exp_q.push_back(d);
    else check("send_timeout", 64'(tries), 64'(0));
    up_if.valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycles(2);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          if (dn_if.valid && dn_if.ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got %0h, expected no beat", dn_if.data);
            end else begin
              check("out_data", 64'(dn_if.data), 64'(exp_q.pop_front()));
            end
          end
          if (!dn_if.valid) check("bubble_data", 64'(dn_if.data), 64'(0));
        end
      end
    join_none

    // Reset state
    cycles(2);
    @(negedge clk);
    reset = 1'b1;
    check("rst_out_valid", 64'(dn_if.valid), 64'(0));
    check("rst_out_data",  64'(dn_if.data),  64'(0));
    check("rst_in_ready",  64'(up_if.ready), 64'(1));
    check("rst_stall_cnt", 64'(stall_cnt),   64'(0));
    @(posedge clk);
    #1;

    // First beat, one-cycle latency
    send(32'h11);
    check("first_valid", 64'(dn_if.valid), 64'(1));
    check("first_data",  64'(dn_if.data),  64'(32'h11));
    wait_empty("first_drained");

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      send(DATA_W'(i));
      check("stream_in_ready", 64'(up_if.ready), 64'(1));
    end
    wait_empty("stream_drained");
    cycles(1);

    // Back-pressure fills the skid entry
    dn_if.ready = 1'b0;
    send(32'hA);
    send(32'hB);
    check("bp_out_data", 64'(dn_if.data),  64'(32'hA));
    check("bp_in_ready", 64'(up_if.ready), 64'(0));
    cycles(2);
    check("bp_hold_data", 64'(dn_if.data), 64'(32'hA));
    dn_if.ready = 1'b1;
    wait_empty("bp_drained");
    check("bp_in_ready_back", 64'(up_if.ready), 64'(1));
    cycles(1);

    // Flush while holding two beats, with a beat offered in the same cycle
    dn_if.ready = 1'b0;
    send(32'hA);
    send(32'hB);
    flush       = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = 32'hC;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 64'(dn_if.valid), 64'(0));
    check("flush_out_data",  64'(dn_if.data),  64'(0));
    check("flush_in_ready",  64'(up_if.ready), 64'(1));
    dn_if.ready = 1'b1;
    cycles(4);

    // Saturating stall counter
    do_reset();
    dn_if.ready = 1'b0;
    send(32'h55);
    check("stall_start", 64'(stall_cnt), 64'(0));
    for (int i = 1; i <= 6; i++) begin
      cycles(1);
      check("stall_cnt", 64'(stall_cnt), 64'((i > 3) ? 3 : i));
    end
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    exp_q.delete();
    check("stall_after_flush", 64'(stall_cnt), 64'(3));
    do_reset();
    check("stall_after_reset", 64'(stall_cnt), 64'(0));

    // Asynchronous reset while in TWO
    send(32'h21);
    send(32'h22);
    check("two_in_ready", 64'(up_if.ready), 64'(0));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_out_valid", 64'(dn_if.valid), 64'(0));
    check("async_out_data",  64'(dn_if.data),  64'(0));
    check("async_in_ready",  64'(up_if.ready), 64'(1));
    check("async_stall_cnt", 64'(stall_cnt),   64'(0));
    exp_q.delete();
    @(negedge clk);
    reset       = 1'b1;
    dn_if.ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(dn_if.valid), 64'(0));
    send(32'h33);
    check("post_rst_data", 64'(dn_if.data), 64'(32'h33));
    wait_empty("final_drained");
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload of DATA_W bits with a valid/ready handshake, back-pressure and synchronous flush. A two-entry skid buffer gives a registered upstream ready. A saturating stall counter supports performance analysis. Each stage boundary instantiates one copy, and the stage packs its own fields into the payload.

Parameters:
DATA_W, 32, payload width in bits (>=1)
FLUSH_VAL, {DATA_W{1'b0}}, payload value presented whenever the stage holds a bubble
CNT_W, 16, stall counter width (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream beat present
in_data  input  DATA_W  upstream payload
in_ready  output  1  stage can accept; registered (flop output)
out_valid  output  1  downstream beat present
out_data  output  DATA_W  downstream payload (main register)
out_ready  input  1  downstream accepts
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives out_valid/out_data) and skid entry (skid_valid, skid_data).
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
- Signals:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - in_ready = ~skid_valid, implemented as its own flop, never combinational from out_ready.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - out_valid=0, out_data=FLUSH_VAL, skid invalid, skid_data=FLUSH_VAL.
  - in_ready=1, stall_cnt=0.
  - State=EMPTY. No beat survives.
- Flush (reset=1, flush=1) has the highest synchronous priority:
  - Next state EMPTY, out_data<=FLUSH_VAL, skid invalid, in_ready<=1.
  - Any beat presented that cycle is dropped even if in_ready=1.
  - A drain in the flush cycle still completes downstream.
  - stall_cnt is not cleared.
- Transitions when flush=0:
  - EMPTY:
    - accept: main<=in_data, go to ONE.
    - No accept: stay; out_data stays FLUSH_VAL.
  - ONE:
    - accept & drain: main<=in_data, stay ONE.
    - accept & ~drain: skid<=in_data, go to TWO, in_ready<=0.
    - ~accept & drain: go to EMPTY, out_data<=FLUSH_VAL.
    - Neither: hold.
  - TWO (in_ready=0, so no accept):
    - drain: main<=skid_data, go to ONE, in_ready<=1.
    - No drain: hold both entries.
- Latency:
  - One cycle. A beat accepted at edge N is on out_data after edge N when main was empty or draining at N.
  - Sustained throughput is 1 beat/cycle with out_ready=1.
- Ordering: strict FIFO; skid data always issues after the main data.
- Bubble rule: whenever out_valid=0, out_data==FLUSH_VAL. Control fields packed at zero therefore read as a NOP.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- in_valid while in_ready=0 has no effect; upstream must hold its beat.

Test Plan:
- Reset release, DATA_W=32, FLUSH_VAL=0: out_valid=0, out_data=0, in_ready=1, stall_cnt=0. Then in_valid=1, in_data=0x11 for one cycle -> next cycle out_valid=1, out_data=0x11.
- Streaming 0x1..0x8 with out_ready=1 every cycle -> out_data 0x1..0x8 on 8 consecutive cycles, in_ready stays 1.
- Back-pressure: out_ready=0, send 0xA, 0xB -> out_data=0xA, in_ready=0 after the second beat. Raise out_ready -> 0xA then 0xB delivered in order, in_ready returns to 1.
- Flush in TWO (holding 0xA, 0xB) with in_valid=1, in_data=0xC the same cycle -> next cycle out_valid=0, out_data=FLUSH_VAL, in_ready=1, and 0xC never appears.
- Stall counter with CNT_W=2: hold out_valid=1, out_ready=0 for 6 cycles -> stall_cnt 1,2,3,3,3,3. A flush does not reset it; reset does.
- Asynchronous reset asserted mid-cycle while in TWO -> outputs clear immediately without a clock edge. After release the state is EMPTY.
